// File: rtl/mips_loader.sv
// Host-side loader for the pipelined MIPS32 core: streams a program into instruction
// memory, releases the core until HLT or timeout, then streams out the low registers.
module mips_loader #(
    parameter int ADDR_W    = 10,
    parameter int DUMP_REGS = 6,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    input  logic              core_halted,
    output logic [4:0]        reg_raddr,
    input  logic [31:0]       reg_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic [4:0]        m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_tmo
);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DUMP,
        DONE
    } state_t;

    localparam logic [5:0]  LAST_IDX  = 6'(DUMP_REGS - 1);
    localparam logic [5:0]  NUM_REGS  = 6'(DUMP_REGS);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wptr;
    logic [5:0]        ridx;
    logic [31:0]       run_cnt;

    logic take_word;
    logic wptr_full;
    logic halt_seen;
    logic tmo_hit;
    logic dump_fire;
    logic last_fire;
    logic dump_load;

    always_comb begin
        s_ready   = (state == LOAD);
        take_word = s_valid && s_ready;
        wptr_full = (wptr == {ADDR_W{1'b1}});
        // run_cnt is 1 in the first RUN cycle, where HALTED may still be stale
        halt_seen = core_halted && (run_cnt > 32'd1);
        tmo_hit   = (TIMEOUT != 0) && (run_cnt == TMO_LIMIT);
        dump_fire = m_valid && m_ready;
        last_fire = dump_fire && m_last;
        dump_load = (state == DUMP) && (!m_valid || dump_fire) && (ridx < NUM_REGS);
        mem_we    = take_word;
        mem_addr  = wptr;
        mem_wdata = s_data;
        reg_raddr = ridx[4:0];
        busy      = ((state == LOAD) && (wptr != '0)) || (state == RUN) || (state == DUMP);
        done      = (state == DONE);
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (take_word && (s_last || wptr_full)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_seen || tmo_hit) begin
                    state_next = DUMP;
                end
            end
            DUMP: begin
                if (last_fire) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            wptr     <= '0;
            run_cnt  <= '0;
            core_run <= 1'b0;
            err_ovf  <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            // the pointer never wraps; a full memory without s_last ends the load
            if (take_word && !wptr_full) begin
                wptr <= wptr + 1'b1;
            end
            if (take_word && wptr_full && !s_last) begin
                err_ovf <= 1'b1;
            end
            if ((state == RUN) && tmo_hit && !halt_seen) begin
                err_tmo <= 1'b1;
            end
            core_run <= (state_next == RUN);
            if (state != RUN) begin
                run_cnt <= 32'd1;
            end else if (run_cnt != '1) begin
                run_cnt <= run_cnt + 32'd1;
            end
        end
    end

    // output register refills on an empty slot or on a handshake, so data holds while stalled
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            ridx    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            m_last  <= 1'b0;
        end else if (last_fire) begin
            m_valid <= 1'b0;
        end else if (dump_load) begin
            m_valid <= 1'b1;
            m_data  <= reg_rdata;
            m_idx   <= ridx[4:0];
            m_last  <= (ridx == LAST_IDX);
            ridx    <= ridx + 6'd1;
        end
    end

endmodule

// File: tb/tb_mips_loader.sv
// Bench for mips_loader: two instances (large memory/no timeout, tiny memory/timeout 50)
// driven by directed steps with random programs, registers and backpressure.
module tb_mips_loader;

    localparam int DREGS = 6;
    localparam int NEVER = 1 << 20;

    logic        clk = 1'b0;
    logic        rst_n       [2];
    logic        s_valid     [2];
    logic [31:0] s_data      [2];
    logic        s_last      [2];
    logic        core_halted [2];
    logic        m_ready     [2];
    logic [31:0] reg_rdata   [2];
    logic [31:0] regs        [2][32];

    logic        s_ready   [2];
    logic        mem_we    [2];
    logic [9:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        core_run  [2];
    logic [4:0]  reg_raddr [2];
    logic        m_valid   [2];
    logic [31:0] m_data    [2];
    logic [4:0]  m_idx     [2];
    logic        m_last    [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err_ovf   [2];
    logic        err_tmo   [2];

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] prog [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int AWG = (g == 0) ? 10 : 3;
        localparam int TMG = (g == 0) ? 0 : 50;
        logic [AWG-1:0] addr;

        mips_loader #(
            .ADDR_W   (AWG),
            .DUMP_REGS(DREGS),
            .TIMEOUT  (TMG)
        ) dut (
            .clk1       (clk),
            .rst_n      (rst_n[g]),
            .s_valid    (s_valid[g]),
            .s_ready    (s_ready[g]),
            .s_data     (s_data[g]),
            .s_last     (s_last[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (addr),
            .mem_wdata  (mem_wdata[g]),
            .core_run   (core_run[g]),
            .core_halted(core_halted[g]),
            .reg_raddr  (reg_raddr[g]),
            .reg_rdata  (reg_rdata[g]),
            .m_valid    (m_valid[g]),
            .m_ready    (m_ready[g]),
            .m_data     (m_data[g]),
            .m_idx      (m_idx[g]),
            .m_last     (m_last[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .err_ovf    (err_ovf[g]),
            .err_tmo    (err_tmo[g])
        );

        assign mem_addr[g]  = 10'(addr);
        assign reg_rdata[g] = regs[g][reg_raddr[g]];
    end

    function automatic int capOf(input int g);
        return (g == 0) ? 1024 : 8;
    endfunction

    function automatic int tmoOf(input int g);
        return (g == 0) ? 0 : 50;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int g, input logic valid, input logic [31:0] data,
                                 input logic last, input logic ready);
        @(posedge clk);
        #1;
        s_valid[g] = valid;
        s_data[g]  = data;
        s_last[g]  = last;
        m_ready[g] = ready;
    endtask

    task automatic checkReset(input int g);
        checkOutput("rst_s_ready", s_ready[g], 1);
        checkOutput("rst_mem_we", mem_we[g], 0);
        checkOutput("rst_m_valid", m_valid[g], 0);
        checkOutput("rst_m_data", m_data[g], 0);
        checkOutput("rst_m_idx", m_idx[g], 0);
        checkOutput("rst_m_last", m_last[g], 0);
        checkOutput("rst_core_run", core_run[g], 0);
        checkOutput("rst_done", done[g], 0);
        checkOutput("rst_busy", busy[g], 0);
        checkOutput("rst_err_ovf", err_ovf[g], 0);
        checkOutput("rst_err_tmo", err_tmo[g], 0);
    endtask

    task automatic resetDut(input int g);
        applyStimulus(g, 0, 0, 0, 0);
        rst_n[g]       = 1'b0;
        core_halted[g] = 1'b0;
        applyStimulus(g, 0, 0, 0, 0);
        @(negedge clk);
        checkReset(g);
        applyStimulus(g, 0, 0, 0, 0);
        rst_n[g] = 1'b1;
    endtask

    task automatic makeProgram(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    task automatic randomRegs(input int g);
        for (int i = 0; i < 32; i++) regs[g][i] = $urandom;
    endtask

    // Words are offered back to back; the model accepts them up to s_last or capacity.
    task automatic loadProgram(input int g, input int n, input bit with_last);
        int acc;
        acc = (with_last && n <= capOf(g)) ? n : capOf(g);
        for (int i = 0; i < acc; i++) begin
            applyStimulus(g, 1, prog[i], with_last && (i == n - 1), 0);
            @(negedge clk);
            checkOutput("load_s_ready", s_ready[g], 1);
            checkOutput("load_mem_we", mem_we[g], 1);
            checkOutput("load_addr", mem_addr[g], i);
            checkOutput("load_data", mem_wdata[g], prog[i]);
            checkOutput("load_busy", busy[g], i != 0);
            checkOutput("load_core_run", core_run[g], 0);
        end
    endtask

    // halt_cycle: RUN cycle in which the core raises HALTED (0 = never).
    task automatic runPhase(input int g, input int halt_cycle, input int extra, input bit exp_ovf);
        int h;
        int t;
        int exp_len;
        int len;
        h       = (halt_cycle == 0) ? NEVER : ((halt_cycle < 2) ? 2 : halt_cycle);
        t       = (tmoOf(g) == 0) ? NEVER : tmoOf(g);
        exp_len = (h <= t) ? h : t;
        len     = 0;
        for (int c = 1; c <= 300; c++) begin
            applyStimulus(g, c <= extra, $urandom, 1'($urandom_range(0, 1)), 0);
            if (c == halt_cycle) core_halted[g] = 1'b1;
            @(negedge clk);
            if (!core_run[g]) break;
            len++;
            checkOutput("run_s_ready", s_ready[g], 0);
            checkOutput("run_mem_we", mem_we[g], 0);
            checkOutput("run_m_valid", m_valid[g], 0);
            checkOutput("run_busy", busy[g], 1);
            checkOutput("run_err_tmo_early", err_tmo[g], 0);
            checkOutput("run_err_ovf", err_ovf[g], exp_ovf);
        end
        checkOutput("run_length", len, exp_len);
        checkOutput("run_err_tmo", err_tmo[g], t < h);
        checkOutput("dump_first_idle", m_valid[g], 0);
        checkOutput("dump_busy", busy[g], 1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic dumpPhase(input int g, input int mode, input bit exp_ovf, input bit exp_tmo);
        int k;
        bit r;
        k = 0;
        for (int c = 0; c < 200 && k < DREGS; c++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            applyStimulus(g, 1'($urandom_range(0, 1)), $urandom, 1'b0, r);
            @(negedge clk);
            checkOutput("dump_mem_we", mem_we[g], 0);
            checkOutput("dump_core_run", core_run[g], 0);
            checkOutput("dump_valid", m_valid[g], 1);
            if (m_valid[g]) begin
                checkOutput("dump_idx", m_idx[g], k);
                checkOutput("dump_data", m_data[g], regs[g][k]);
                checkOutput("dump_last", m_last[g], k == DREGS - 1);
                if (r) k++;
            end
        end
        checkOutput("dump_count", k, DREGS);
        applyStimulus(g, 1, $urandom, 1, 1);
        @(negedge clk);
        checkOutput("done_done", done[g], 1);
        checkOutput("done_busy", busy[g], 0);
        checkOutput("done_m_valid", m_valid[g], 0);
        checkOutput("done_core_run", core_run[g], 0);
        checkOutput("done_s_ready", s_ready[g], 0);
        checkOutput("done_mem_we", mem_we[g], 0);
        checkOutput("done_err_ovf", err_ovf[g], exp_ovf);
        checkOutput("done_err_tmo", err_tmo[g], exp_tmo);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int hc;
        int k;
        for (int g = 0; g < 2; g++) begin
            rst_n[g]       = 1'b0;
            s_valid[g]     = 1'b0;
            s_data[g]      = '0;
            s_last[g]      = 1'b0;
            core_halted[g] = 1'b0;
            m_ready[g]     = 1'b0;
            randomRegs(g);
        end
        $display("[TB] starting mips_loader bench");

        // reference program, halt 40 cycles after release, full-rate dump
        resetDut(0);
        resetDut(1);
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        for (int i = 0; i < 32; i++) regs[0][i] = i;
        regs[0][1] = 10;
        regs[0][2] = 20;
        regs[0][3] = 25;
        regs[0][4] = 30;
        regs[0][5] = 55;
        loadProgram(0, 9, 1);
        runPhase(0, 41, 1, 0);
        dumpPhase(0, 0, 0, 0);

        // random program, 1,0,0 backpressure
        resetDut(0);
        n  = $urandom_range(1, 20);
        hc = $urandom_range(2, 30);
        makeProgram(n);
        randomRegs(0);
        loadProgram(0, n, 1);
        runPhase(0, hc, 1, 0);
        dumpPhase(0, 1, 0, 0);

        // random program, random backpressure
        resetDut(0);
        n  = $urandom_range(1, 20);
        hc = $urandom_range(2, 30);
        makeProgram(n);
        randomRegs(0);
        loadProgram(0, n, 1);
        runPhase(0, hc, 1, 0);
        dumpPhase(0, 2, 0, 0);

        // overflow: 10 words, no s_last, 8-word memory
        resetDut(1);
        makeProgram(10);
        randomRegs(1);
        loadProgram(1, 10, 0);
        runPhase(1, 5, 2, 1);
        dumpPhase(1, 2, 1, 0);

        // exactly full memory with s_last on the final slot is not an overflow
        resetDut(1);
        makeProgram(8);
        randomRegs(1);
        loadProgram(1, 8, 1);
        runPhase(1, 3, 1, 0);
        dumpPhase(1, 0, 0, 0);

        // timeout with HALTED never raised
        resetDut(1);
        makeProgram(5);
        randomRegs(1);
        loadProgram(1, 5, 1);
        runPhase(1, 0, 1, 0);
        dumpPhase(1, 0, 0, 1);

        // halt on the timeout cycle wins
        resetDut(1);
        makeProgram(4);
        randomRegs(1);
        loadProgram(1, 4, 1);
        runPhase(1, 50, 1, 0);
        dumpPhase(1, 2, 0, 0);

        // stale HALTED through load, then reset during the third dump word
        resetDut(0);
        core_halted[0] = 1'b1;
        makeProgram(3);
        randomRegs(0);
        loadProgram(0, 3, 1);
        runPhase(0, 1, 1, 0);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(0, 0, 0, 0, 1);
            @(negedge clk);
            if (m_valid[0]) begin
                checkOutput("mid_idx", m_idx[0], k);
                checkOutput("mid_data", m_data[0], regs[0][k]);
                if (k == 2) break;
                k++;
            end
        end
        checkOutput("mid_reached_third", k, 2);
        rst_n[0]       = 1'b0;
        core_halted[0] = 1'b0;
        applyStimulus(0, 0, 0, 0, 1);
        @(negedge clk);
        checkReset(0);
        applyStimulus(0, 0, 0, 0, 1);
        rst_n[0] = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_m_valid", m_valid[0], 0);
        checkOutput("post_rst_s_ready", s_ready[0], 1);
        applyStimulus(0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("post_rel_m_valid", m_valid[0], 0);
        checkOutput("post_rel_s_ready", s_ready[0], 1);
        checkOutput("post_rel_done", done[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_loader.md
Name: mips_loader

Overview:
- Single-clock host-side engine for the pipelined MIPS32 core; it replaces direct hierarchical preloading and read-back in simulation.
- It accepts a program as a valid/ready word stream and writes it into instruction memory from address 0.
- It then releases the core and waits for HLT (or a timeout).
- It finally reads register file entries R0..R(DUMP_REGS-1) and streams them out on a second valid/ready interface.

Parameters:
ADDR_W, 10, instruction-memory word-address width (capacity 2^ADDR_W words)
DUMP_REGS, 6, number of registers streamed out after halt (1..32)
TIMEOUT, 0, max RUN cycles before forced dump; 0 disables timeout

Ports:
clk1  in  1  clock (single clock; all logic on rising edge)
rst_n  in  1  synchronous active-low reset
s_valid  in  1  program word valid
s_ready  out  1  loader accepts program word
s_data  in  32  program word
s_last  in  1  marks final program word
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  instruction memory write address
mem_wdata  out  32  instruction memory write data
core_run  out  1  high = core released (core clears HALTED, PC=0, TAKEN_BRANCH=0 while low)
core_halted  in  1  core HALTED flag
reg_raddr  out  5  register-file read address
reg_rdata  in  32  register-file read data, combinational from reg_raddr
m_valid  out  1  dump word valid
m_ready  in  1  dump consumer ready
m_data  out  32  dump word (value of register m_idx)
m_idx  out  5  register index of m_data
m_last  out  1  high with final dump word
busy  out  1  high in LOAD-after-first-word, RUN, DUMP
done  out  1  high in DONE
err_ovf  out  1  sticky: memory filled without s_last
err_tmo  out  1  sticky: RUN timed out

Behaviour:
- States: LOAD, RUN, DUMP, DONE.
- Reset (rst_n=0 at a rising edge) has priority over everything in every state:
  - state=LOAD; write pointer wptr=0; ridx=0; run counter=0.
  - Outputs: m_valid=0, m_data=0, m_idx=0, m_last=0, core_run=0, done=0, err_ovf=0, err_tmo=0, busy=0.
  - Reset mid-operation aborts immediately. No further mem_we or m_valid after the reset edge.
- LOAD:
  - s_ready=1. mem_we = s_valid & s_ready (combinational). mem_addr=wptr, mem_wdata=s_data.
  - Each handshake increments wptr; busy=1 once wptr!=0.
  - On a handshake with s_last=1, go to RUN next cycle.
  - On a handshake at wptr=2^ADDR_W-1 with s_last=0: word is written, err_ovf set, go to RUN. No wrap.
  - s_ready=0 in all other states; stream words offered then are not written.
- RUN:
  - core_run=1 (registered; rises the cycle after the last write).
  - Run counter counts RUN cycles starting at 1.
  - core_halted is ignored in the first RUN cycle, to skip the stale HALTED value. From the second cycle, core_halted=1 moves to DUMP next cycle.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without halt: set err_tmo, go to DUMP.
  - If halt and timeout coincide, halt wins and err_tmo stays 0.
- DUMP:
  - core_run=0.
  - reg_raddr=ridx.
  - The output register loads {m_data=reg_rdata, m_idx=ridx, m_last=(ridx==DUMP_REGS-1)} and sets m_valid whenever m_valid=0 or (m_valid & m_ready), provided ridx<DUMP_REGS; ridx then increments.
  - Throughput is one word per cycle under continuous m_ready. First m_valid appears the cycle after entering DUMP.
  - m_data, m_idx and m_last are held stable while m_valid & !m_ready.
  - When the m_last word handshakes: m_valid=0, go to DONE.
- DONE:
  - done=1, busy=0, core_run=0; stays until reset.
  - err flags remain visible.

Test Plan:
- Nine-word program load (words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000), s_valid continuous, s_last on word 9 -> mem_we for exactly 9 cycles at addresses 0..8 with matching data; core_run rises the next cycle.
- Continuing that run, core model asserts core_halted 40 cycles later, Reg[k]=k except R1=10, R2=20, R3=25, R4=30, R5=55; m_ready=1 -> dump stream (idx,data) = (0,0)(1,10)(2,20)(3,25)(4,30)(5,55), one per cycle, m_last on idx 5, then done=1; err_ovf=err_tmo=0.
- Backpressure: m_ready toggling 1,0,0,1,... -> every register delivered exactly once, in order; m_data/m_idx stable while stalled.
- Overflow: ADDR_W=3, 10 words with no s_last -> 8 writes (addr 0..7), err_ovf=1, s_ready=0 for words 9-10, RUN entered.
- Timeout: TIMEOUT=50, core_halted held 0 -> err_tmo=1 after 50 RUN cycles, dump still produces DUMP_REGS words.
- Stale halt / reset mid-dump: core_halted=1 throughout load -> RUN lasts exactly 2 cycles. rst_n low during the 3rd dump word -> next cycle m_valid=0, state LOAD, s_ready=1, all flags 0.
